// File: rtl/time_setter.sv
// time_setter: key-driven hh:mm:ss editor with
// auto-repeat increment, commit strobe and field blink.
module time_setter #(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int BLINK_HALF   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_next,
  input  logic       key_inc,
  input  logic       inc_level,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic [5:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic       load,
  output logic       editing,
  output logic [1:0] field,
  output logic [5:0] blink_mask
);

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HH,
    EDIT_MM,
    EDIT_SS,
    COMMIT
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [5:0]  hh;
  logic [5:0]  mm;
  logic [5:0]  ss;
  logic [31:0] hold;
  logic        rep;
  logic [31:0] bcnt;
  logic [31:0] nxt_bcnt;
  logic        phase;
  logic        nxt_phase;
  logic        in_edit;
  logic        tick;
  logic        inc;
  logic [5:0]  nxt_mask;

  assign set_hours   = hh;
  assign set_minutes = mm;
  assign set_seconds = ss;

  // field and editing decode straight from the state
  always_comb begin
    editing = (state != IDLE);
    field   = 2'd0;
    case (state)
      EDIT_HH: field = 2'd1;
      EDIT_MM: field = 2'd2;
      EDIT_SS: field = 2'd3;
      default: field = 2'd0;
    endcase
  end

  // next state, increment request and next blink state
  always_comb begin
    in_edit = (state == EDIT_HH) ||
              (state == EDIT_MM) ||
              (state == EDIT_SS);
    tick = in_edit && inc_level &&
           (rep ? (hold == 32'(REPEAT_RATE))
                : (hold == 32'(REPEAT_DELAY)));
    inc = in_edit && !key_start && (key_inc || tick);

    nxt = state;
    case (state)
      IDLE:    if (key_start) nxt = EDIT_HH;
      EDIT_HH: if (key_start) nxt = IDLE;
               else if (key_next) nxt = EDIT_MM;
      EDIT_MM: if (key_start) nxt = IDLE;
               else if (key_next) nxt = EDIT_SS;
      EDIT_SS: if (key_start) nxt = IDLE;
               else if (key_next) nxt = COMMIT;
      default: nxt = IDLE;
    endcase

    nxt_phase = phase;
    nxt_bcnt  = bcnt + 32'd1;
    if (nxt == IDLE || inc || nxt != state) begin
      nxt_phase = 1'b0;
      nxt_bcnt  = 32'd0;
    end else if (bcnt == 32'(BLINK_HALF - 1)) begin
      nxt_phase = ~phase;
      nxt_bcnt  = 32'd0;
    end

    nxt_mask = 6'b000000;
    if (nxt_phase) begin
      case (nxt)
        EDIT_HH: nxt_mask = 6'b110000;
        EDIT_MM: nxt_mask = 6'b001100;
        EDIT_SS: nxt_mask = 6'b000011;
        default: nxt_mask = 6'b000000;
      endcase
    end
  end

  // state, edit registers, repeat and blink counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load       <= 1'b0;
      hh         <= 6'd0;
      mm         <= 6'd0;
      ss         <= 6'd0;
      hold       <= 32'd0;
      rep        <= 1'b0;
      bcnt       <= 32'd0;
      phase      <= 1'b0;
      blink_mask <= 6'd0;
    end else begin
      state      <= nxt;
      load       <= (nxt == COMMIT);
      bcnt       <= nxt_bcnt;
      phase      <= nxt_phase;
      blink_mask <= nxt_mask;

      if (nxt != state || !in_edit || !inc_level) begin
        hold <= 32'd0;
        rep  <= 1'b0;
      end else if (tick) begin
        hold <= 32'd1;
        rep  <= 1'b1;
      end else begin
        hold <= hold + 32'd1;
      end

      if (state == IDLE && key_start) begin
        hh <= (cur_hours   > 6'd23) ? 6'd0 : cur_hours;
        mm <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
        ss <= (cur_seconds > 6'd59) ? 6'd0 : cur_seconds;
      end else if (inc) begin
        case (state)
          EDIT_HH: hh <= (hh == 6'd23) ? 6'd0 : hh + 6'd1;
          EDIT_MM: mm <= (mm == 6'd59) ? 6'd0 : mm + 6'd1;
          EDIT_SS: ss <= (ss == 6'd59) ? 6'd0 : ss + 6'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: directed bench for time_setter
// with small repeat and blink periods.
module tb_time_setter;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_start;
  logic       key_next;
  logic       key_inc;
  logic       inc_level;
  logic [5:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic [5:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       load;
  logic       editing;
  logic [1:0] field;
  logic [5:0] blink_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_setter #(
    .REPEAT_DELAY(8),
    .REPEAT_RATE (3),
    .BLINK_HALF  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start  (key_start),
    .key_next   (key_next),
    .key_inc    (key_inc),
    .inc_level  (inc_level),
    .cur_hours  (cur_hours),
    .cur_minutes(cur_minutes),
    .cur_seconds(cur_seconds),
    .set_hours  (set_hours),
    .set_minutes(set_minutes),
    .set_seconds(set_seconds),
    .load       (load),
    .editing    (editing),
    .field      (field),
    .blink_mask (blink_mask)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    key_start = 1'b1;
    cyc();
    key_start = 1'b0;
  endtask

  task automatic press_next();
    key_next = 1'b1;
    cyc();
    key_next = 1'b0;
  endtask

  task automatic press_inc();
    key_inc = 1'b1;
    cyc();
    key_inc = 1'b0;
  endtask

  task automatic set_cur(input logic [5:0] h,
                         input logic [5:0] m,
                         input logic [5:0] s);
    cur_hours   = h;
    cur_minutes = m;
    cur_seconds = s;
  endtask

  initial begin
    int exp_mm;
    rst       = 1'b1;
    key_start = 1'b0;
    key_next  = 1'b0;
    key_inc   = 1'b0;
    inc_level = 1'b0;
    set_cur(6'd0, 6'd0, 6'd0);
    cyc();
    cyc();
    chk("rst_load", load, 0);
    chk("rst_editing", editing, 0);
    chk("rst_field", field, 0);
    chk("rst_mask", blink_mask, 0);
    chk("rst_hours", set_hours, 0);
    rst = 1'b0;
    cyc();
    chk("idle_editing", editing, 0);

    // capture and commit
    set_cur(6'd12, 6'd34, 6'd56);
    press_start();
    chk("cap_editing", editing, 1);
    chk("cap_field", field, 1);
    chk("cap_hours", set_hours, 12);
    chk("cap_minutes", set_minutes, 34);
    chk("cap_seconds", set_seconds, 56);
    chk("cap_load", load, 0);
    press_next();
    chk("next_field2", field, 2);
    press_next();
    chk("next_field3", field, 3);
    chk("pre_commit_load", load, 0);
    press_next();
    chk("commit_load", load, 1);
    chk("commit_editing", editing, 1);
    chk("commit_hours", set_hours, 12);
    chk("commit_minutes", set_minutes, 34);
    chk("commit_seconds", set_seconds, 56);
    cyc();
    chk("post_commit_load", load, 0);
    chk("post_commit_editing", editing, 0);
    cyc();
    chk("idle_load", load, 0);

    // wrap, no carry
    set_cur(6'd23, 6'd59, 6'd59);
    press_start();
    press_inc();
    chk("wrap_hours", set_hours, 0);
    chk("wrap_nocarry_mm", set_minutes, 59);
    press_next();
    press_inc();
    chk("wrap_minutes", set_minutes, 0);
    chk("wrap_nocarry_hh", set_hours, 0);
    chk("wrap_nocarry_ss", set_seconds, 59);
    press_next();
    press_inc();
    chk("wrap_seconds", set_seconds, 0);
    press_next();
    chk("wrap_load", load, 1);
    chk("wrap_set_h", set_hours, 0);
    chk("wrap_set_m", set_minutes, 0);
    chk("wrap_set_s", set_seconds, 0);
    cyc();

    // auto-repeat in EDIT_MM
    set_cur(6'd0, 6'd0, 6'd0);
    press_start();
    press_next();
    key_inc   = 1'b1;
    inc_level = 1'b1;
    cyc();
    key_inc = 1'b0;
    chk("rep_first", set_minutes, 1);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      exp_mm = (i >= 8) ? 2 + (i - 8) / 3 : 1;
      chk($sformatf("rep_mm_%0d", i),
          set_minutes, exp_mm);
    end
    inc_level = 1'b0;
    cyc();
    cyc();
    chk("rep_final_mm", set_minutes, 6);
    chk("rep_hours", set_hours, 0);
    chk("rep_seconds", set_seconds, 0);
    press_start();
    chk("rep_cancel", editing, 0);

    // cancel keeps edit registers, no load
    set_cur(6'd3, 6'd0, 6'd0);
    press_start();
    press_inc();
    press_inc();
    chk("cancel_pre_h", set_hours, 5);
    press_start();
    chk("cancel_editing", editing, 0);
    chk("cancel_load", load, 0);
    chk("cancel_keep_h", set_hours, 5);
    cyc();
    chk("cancel_load2", load, 0);

    // reset mid-edit
    set_cur(6'd9, 6'd8, 6'd7);
    press_start();
    press_next();
    press_next();
    chk("mid_field", field, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_editing", editing, 0);
    chk("mid_rst_load", load, 0);
    chk("mid_rst_field", field, 0);
    chk("mid_rst_h", set_hours, 0);
    chk("mid_rst_m", set_minutes, 0);
    chk("mid_rst_s", set_seconds, 0);
    chk("mid_rst_mask", blink_mask, 0);
    cyc();
    chk("mid_rst_load2", load, 0);

    // blink in EDIT_MM
    set_cur(6'd0, 6'd0, 6'd0);
    press_start();
    press_next();
    chk("blink_0", blink_mask, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk($sformatf("blink_%0d", i), blink_mask,
          ((i / 4) % 2 == 1) ? 6'b001100 : 6'b0);
    end
    press_inc();
    chk("blink_inc_0", blink_mask, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("blink_inc_%0d", i),
          blink_mask, 0);
    end
    cyc();
    chk("blink_inc_4", blink_mask, 6'b001100);
    press_start();
    chk("blink_idle_0", blink_mask, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk($sformatf("blink_idle_%0d", i),
          blink_mask, 0);
    end

    // inc with next, out-of-range capture
    set_cur(6'd7, 6'd0, 6'd0);
    press_start();
    key_inc  = 1'b1;
    key_next = 1'b1;
    cyc();
    key_inc  = 1'b0;
    key_next = 1'b0;
    chk("simul_hours", set_hours, 8);
    chk("simul_field", field, 2);
    chk("simul_minutes", set_minutes, 0);
    press_start();
    set_cur(6'd30, 6'd45, 6'd60);
    press_start();
    chk("oor_hours", set_hours, 0);
    chk("oor_minutes", set_minutes, 45);
    chk("oor_seconds", set_seconds, 0);
    press_start();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
